// File: rtl/averager_pkg.sv
// Shared types and default widths for the enable-triggered sample averager.
package averager_pkg;

    localparam int DATA_W_DEF = 14;
    localparam int CNT_W_DEF  = 16;
    localparam int ACC_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/enable_triggered_averager_if.sv
// Bus between the enable/read-back PIOs and the averager.
interface enable_triggered_averager_if #(
    parameter int DATA_W = averager_pkg::DATA_W_DEF,
    parameter int CNT_W  = averager_pkg::CNT_W_DEF,
    parameter int ACC_W  = averager_pkg::ACC_W_DEF
) ();

    logic                     enable;
    logic [CNT_W-1:0]         n_samples;
    logic signed [DATA_W-1:0] data_in;
    logic                     data_valid;
    logic signed [ACC_W-1:0]  acc_out;
    logic                     acc_valid;
    logic                     busy;
    logic                     done;

    modport master (
        output enable, n_samples, data_in, data_valid,
        input  acc_out, acc_valid, busy, done
    );

    modport slave (
        input  enable, n_samples, data_in, data_valid,
        output acc_out, acc_valid, busy, done
    );

endinterface

// File: rtl/enable_edge_detect.sv
// Rise/fall pulses on the enable level; the delay register resets high so an
// enable already asserted at reset release is not seen as a rising edge.
module enable_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic i_enable,
    output logic o_rise,
    output logic o_fall
);

    logic r_enable_d;

    // One-cycle delayed copy of enable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_enable_d <= 1'b1;
        end else begin
            r_enable_d <= i_enable;
        end
    end

    assign o_rise = i_enable & ~r_enable_d;
    assign o_fall = ~i_enable & r_enable_d;

endmodule

// File: rtl/enable_triggered_averager_chk.sv
// Simulation checks: parameter sizing and output-flag consistency.
module enable_triggered_averager_chk #(
    parameter int DATA_W = 14,
    parameter int CNT_W  = 16,
    parameter int ACC_W  = 32
) (
    input logic clk,
    input logic reset_n,
    input logic acc_valid,
    input logic busy,
    input logic done
);

    // Sampled once per clock outside reset
    always @(posedge clk) begin
        if (reset_n) begin
            assert (ACC_W >= DATA_W + CNT_W)
                else $error("averager: ACC_W too small, sum may wrap");
            assert (!(busy && done))
                else $error("averager: busy and done both high");
            assert (!acc_valid || done)
                else $error("averager: acc_valid outside DONE");
        end
    end

endmodule

// File: rtl/enable_triggered_averager.sv
// Captures n_samples signed samples after an enable rising edge and returns
// their sum; enable low aborts a capture or clears done.
module enable_triggered_averager
    import averager_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input logic                        clk,
    input logic                        reset_n,
    enable_triggered_averager_if.slave bus
);

    logic                    w_rise;
    logic                    w_fall;
    logic                    w_last;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]        r_n_lat;
    logic [CNT_W-1:0]        w_n_lat_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic signed [ACC_W-1:0] r_acc_out;
    logic signed [ACC_W-1:0] w_acc_out_nxt;
    logic                    r_acc_valid;
    logic                    w_acc_valid_nxt;
    logic                    r_busy;
    logic                    r_done;

    enable_edge_detect u_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_enable (bus.enable),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    assign w_acc_sum = r_acc + {{(ACC_W-DATA_W){bus.data_in[DATA_W-1]}}, bus.data_in};
    assign w_last    = bus.data_valid && (r_cnt == (r_n_lat - CNT_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort wins over a coincident last sample
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    if (bus.n_samples == {CNT_W{1'b0}}) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                end else if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output next values
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_n_lat_nxt     = r_n_lat;
        w_acc_nxt       = r_acc;
        w_acc_out_nxt   = r_acc_out;
        w_acc_valid_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_n_lat_nxt = bus.n_samples;
                    w_acc_nxt   = {ACC_W{1'b0}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    if (bus.n_samples == {CNT_W{1'b0}}) begin
                        w_acc_out_nxt   = {ACC_W{1'b0}};
                        w_acc_valid_nxt = 1'b1;
                    end else begin
                        w_acc_valid_nxt = 1'b0;
                    end
                end else begin
                    w_acc_valid_nxt = 1'b0;
                end
            end
            RUN: begin
                if (!w_fall && bus.data_valid) begin
                    w_acc_nxt = w_acc_sum;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_last) begin
                        w_acc_out_nxt   = w_acc_sum;
                        w_acc_valid_nxt = 1'b1;
                    end else begin
                        w_acc_valid_nxt = 1'b0;
                    end
                end else begin
                    w_acc_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_acc_valid_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt       <= {CNT_W{1'b0}};
            r_n_lat     <= {CNT_W{1'b0}};
            r_acc       <= {ACC_W{1'b0}};
            r_acc_out   <= {ACC_W{1'b0}};
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_n_lat     <= w_n_lat_nxt;
            r_acc       <= w_acc_nxt;
            r_acc_out   <= w_acc_out_nxt;
            r_acc_valid <= w_acc_valid_nxt;
            r_busy      <= (w_state_nxt == RUN);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    assign bus.acc_out   = r_acc_out;
    assign bus.acc_valid = r_acc_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    enable_triggered_averager_chk #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .ACC_W  (ACC_W)
    ) u_chk (
        .clk       (clk),
        .reset_n   (reset_n),
        .acc_valid (r_acc_valid),
        .busy      (r_busy),
        .done      (r_done)
    );

endmodule
